// File: rtl/aes_core_scheduler.sv
// aes_core_scheduler: shares one AES core between two 128-bit block requesters.
// Round-robin arbitration, one block in flight, result returned with a channel tag.
// Optional watchdog on a stalled core: define AES_SCHED_WATCHDOG_EN.
module aes_core_scheduler #(
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ack,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ack,
  output logic              core_start,
  output logic [DATA_W-1:0] core_data_in,
  input  logic              core_complete,
  input  logic [DATA_W-1:0] core_data_out,
  input  logic              res_full,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_tag,
  output logic              busy,
  output logic [CNT_W-1:0]  blk_count,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    BUSY    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  state_t state, state_next;

  // Round-robin pointer: channel preferred when both request at once
  logic ptr, ptr_next;
  logic grant;

  logic              req0_ack_next, req1_ack_next, core_start_next;
  logic [DATA_W-1:0] core_data_next, res_data_next;
  logic              res_valid_next, res_tag_next, busy_next;
  logic [CNT_W-1:0]  count_next;

`ifdef AES_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt, wd_next;
  logic            timeout_next;
`else
  // TIMEOUT_CYCLES only has meaning when the watchdog is built in
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES > 0);
  assign timeout_err = 1'b0;
`endif

  // Channel choice: a lone requester wins outright, a tie goes to the pointer
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ptr;
    else                          grant = req1_valid;
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and next-output decode; every output leaves the block registered
  always_comb begin
    state_next      = state;
    ptr_next        = ptr;
    req0_ack_next   = 1'b0;
    req1_ack_next   = 1'b0;
    core_start_next = 1'b0;
    core_data_next  = core_data_in;
    res_valid_next  = 1'b0;
    res_data_next   = res_data;
    res_tag_next    = res_tag;
    count_next      = blk_count;
`ifdef AES_SCHED_WATCHDOG_EN
    wd_next         = wd_cnt;
    timeout_next    = timeout_err;
`endif
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          core_data_next = grant ? req1_data : req0_data;
          res_tag_next   = grant;
          req0_ack_next  = ~grant;
          req1_ack_next  = grant;
          state_next     = ISSUE;
        end
      end
      ISSUE: begin
        core_start_next = 1'b1;
        state_next      = BUSY;
`ifdef AES_SCHED_WATCHDOG_EN
        wd_next         = '0;
`endif
      end
      BUSY: begin
        if (core_complete) begin
          res_data_next = core_data_out;
          state_next    = DELIVER;
        end
`ifdef AES_SCHED_WATCHDOG_EN
        else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_next = 1'b1;
          ptr_next     = ~res_tag;
          state_next   = IDLE;
        end else begin
          wd_next = wd_cnt + 1'b1;
        end
`endif
      end
      DELIVER: begin
        if (!res_full) begin
          res_valid_next = 1'b1;
          count_next     = blk_count + 1'b1;
          ptr_next       = ~res_tag;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr          <= 1'b0;
      req0_ack     <= 1'b0;
      req1_ack     <= 1'b0;
      core_start   <= 1'b0;
      core_data_in <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_tag      <= 1'b0;
      busy         <= 1'b0;
      blk_count    <= '0;
    end else begin
      ptr          <= ptr_next;
      req0_ack     <= req0_ack_next;
      req1_ack     <= req1_ack_next;
      core_start   <= core_start_next;
      core_data_in <= core_data_next;
      res_valid    <= res_valid_next;
      res_data     <= res_data_next;
      res_tag      <= res_tag_next;
      busy         <= busy_next;
      blk_count    <= count_next;
    end
  end

`ifdef AES_SCHED_WATCHDOG_EN
  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt      <= wd_next;
      timeout_err <= timeout_next;
    end
  end
`endif

endmodule

// File: tb/tb_aes_core_scheduler.sv
// tb_aes_core_scheduler: directed, self-checking bench for aes_core_scheduler.
// The watchdog scenario is built only when AES_SCHED_WATCHDOG_EN is defined.
module tb_aes_core_scheduler;

  localparam int DATA_W = 128;
  localparam int CNT_W  = 16;

  localparam logic [DATA_W-1:0] PT0 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [DATA_W-1:0] CT0 = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  localparam logic [DATA_W-1:0] PT1 = 128'hA5A5A5A5_11111111_22222222_5A5A5A5A;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              req0_valid, req1_valid;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ack, req1_ack;
  logic              core_start, core_complete;
  logic [DATA_W-1:0] core_data_in, core_data_out;
  logic              res_full, res_valid, res_tag, busy, timeout_err;
  logic [DATA_W-1:0] res_data;
  logic [CNT_W-1:0]  blk_count;

  int checks   = 0;
  int failures = 0;

  aes_core_scheduler #(
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(8),
    .CNT_W         (CNT_W)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ack     (req0_ack),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ack     (req1_ack),
    .core_start   (core_start),
    .core_data_in (core_data_in),
    .core_complete(core_complete),
    .core_data_out(core_data_out),
    .res_full     (res_full),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_tag      (res_tag),
    .busy         (busy),
    .blk_count    (blk_count),
    .timeout_err  (timeout_err)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [DATA_W-1:0] got,
                              input logic [DATA_W-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Run the core through one block: start already seen, complete after 'lat' cycles
  task automatic finish_block(input int lat, input logic [DATA_W-1:0] ct);
    for (int i = 1; i < lat; i++) step();
    core_complete = 1'b1;
    core_data_out = ct;
    step();
    core_complete = 1'b0;
    core_data_out = '0;
  endtask

  initial begin
    n_rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = PT0;   req1_data = PT1;
    core_complete = 1'b0; core_data_out = '0;
    res_full = 1'b0;
    #12;
    check_output("rst_busy", busy, 0);
    check_output("rst_ack0", req0_ack, 0);
    check_output("rst_start", core_start, 0);
    check_output("rst_count", blk_count, 0);
    check_output("rst_timeout", timeout_err, 0);
    n_rst = 1'b1;
    step();

    // Single block on ch0
    $display("[TB] single block");
    req0_valid = 1'b1;
    step();
    check_output("s_ack0", req0_ack, 1);
    check_output("s_start_early", core_start, 0);
    check_output("s_core_in", core_data_in, PT0);
    req0_valid = 1'b0;
    step();
    check_output("s_ack0_pulse", req0_ack, 0);
    check_output("s_start", core_start, 1);
    step();
    check_output("s_start_pulse", core_start, 0);
    finish_block(20, CT0);
    check_output("s_deliver_wait", res_valid, 0);
    step();
    check_output("s_res_valid", res_valid, 1);
    check_output("s_res_data", res_data, CT0);
    check_output("s_res_tag", res_tag, 0);
    check_output("s_count", blk_count, 1);
    check_output("s_idle", busy, 0);
    step();
    check_output("s_res_pulse", res_valid, 0);

    // Spurious complete in IDLE, then in ISSUE
    $display("[TB] spurious complete");
    core_complete = 1'b1;
    step();
    core_complete = 1'b0;
    check_output("sp_idle_busy", busy, 0);
    check_output("sp_idle_res", res_valid, 0);
    check_output("sp_idle_count", blk_count, 1);
    req1_valid = 1'b1;
    step();
    check_output("sp_ack1", req1_ack, 1);
    req1_valid = 1'b0;
    core_complete = 1'b1;
    core_data_out = CT0;
    step();
    core_complete = 1'b0;
    check_output("sp_issue_start", core_start, 1);
    step();
    check_output("sp_issue_busy", busy, 1);
    check_output("sp_issue_res", res_valid, 0);
    finish_block(3, ~CT0);
    step();
    check_output("sp_res_valid", res_valid, 1);
    check_output("sp_res_data", res_data, ~CT0);
    check_output("sp_res_tag", res_tag, 1);
    check_output("sp_count", blk_count, 2);

    // Contention: both channels valid for four blocks, ch0 first
    $display("[TB] contention");
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      logic exp_ch;
      logic [DATA_W-1:0] ct;
      exp_ch = b[0];
      ct = {4{32'hC0DE0000 + 32'(b)}};
      step();
      check_output("c_ack0", req0_ack, !exp_ch);
      check_output("c_ack1", req1_ack, exp_ch);
      check_output("c_core_in", core_data_in, exp_ch ? PT1 : PT0);
      step();
      finish_block(2, ct);
      step();
      check_output("c_res_valid", res_valid, 1);
      check_output("c_res_tag", res_tag, exp_ch);
      check_output("c_res_data", res_data, ct);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_output("c_count", blk_count, 6);

    // Backpressure: res_full high for 10 cycles after complete, ch1 waiting
    $display("[TB] backpressure");
    step();
    req0_valid = 1'b1;
    step();
    check_output("bp_ack0", req0_ack, 1);
    req0_valid = 1'b0;
    step();
    res_full = 1'b1;
    req1_valid = 1'b1;
    finish_block(4, CT0);
    for (int i = 0; i < 10; i++) begin
      check_output("bp_hold_res", res_valid, 0);
      check_output("bp_hold_ack1", req1_ack, 0);
      check_output("bp_hold_busy", busy, 1);
      step();
    end
    res_full = 1'b0;
    step();
    check_output("bp_res_valid", res_valid, 1);
    check_output("bp_res_data", res_data, CT0);
    check_output("bp_res_tag", res_tag, 0);
    check_output("bp_count", blk_count, 7);
    step();
    check_output("bp_next_ack1", req1_ack, 1);
    req1_valid = 1'b0;
    step();
    step();

    // Reset for two cycles while ch1's block is BUSY
    $display("[TB] reset mid-busy");
    check_output("r_pre_busy", busy, 1);
    n_rst = 1'b0;
    #1;
    check_output("r_busy", busy, 0);
    check_output("r_count", blk_count, 0);
    check_output("r_res_data", res_data, 0);
    check_output("r_core_in", core_data_in, 0);
    step();
    step();
    n_rst = 1'b1;
    core_complete = 1'b1;
    core_data_out = CT0;
    step();
    core_complete = 1'b0;
    step();
    check_output("r_late_busy", busy, 0);
    check_output("r_late_res", res_valid, 0);
    check_output("r_late_count", blk_count, 0);
    req0_valid = 1'b1;
    step();
    check_output("r_ack0", req0_ack, 1);
    req0_valid = 1'b0;
    step();
    check_output("r_start", core_start, 1);
    finish_block(5, CT0);
    step();
    check_output("r_res_valid", res_valid, 1);
    check_output("r_res_tag", res_tag, 0);
    check_output("r_count_after", blk_count, 1);
    step();

`ifdef AES_SCHED_WATCHDOG_EN
    // Watchdog: core never completes, req1 queued behind ch0
    $display("[TB] watchdog");
    req0_valid = 1'b1;
    step();
    check_output("w_ack0", req0_ack, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    step();
    check_output("w_start", core_start, 1);
    for (int i = 1; i < 8; i++) step();
    check_output("w_before_err", timeout_err, 0);
    check_output("w_before_busy", busy, 1);
    step();
    check_output("w_err", timeout_err, 1);
    check_output("w_idle", busy, 0);
    check_output("w_no_res", res_valid, 0);
    check_output("w_count", blk_count, 1);
    step();
    check_output("w_ack1", req1_ack, 1);
    check_output("w_sticky", timeout_err, 1);
    req1_valid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_core_scheduler.md
Name: aes_core_scheduler

Overview:
- Shares the single AES core (aes_control) between two 128-bit block requesters: ch0 is the USB data-endpoint packer and ch1 is a second endpoint or a loopback path.
- Arbitrates round-robin and launches one block at a time with a single-cycle start strobe.
- Waits for the core's complete pulse, then returns the ciphertext with a channel tag to the encrypted-data FIFO side. Honours backpressure from that side.
- Sits between the extract_fifo outputs and the aes_control / encrypted_fifo pair, in the fast clk domain.

Parameters:
- DATA_W, 128, block width in bits; 128 is the only supported value.
- TIMEOUT_CYCLES, 255, watchdog limit in clk cycles while BUSY (used only with the optional feature).
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- req0_valid  in  1  ch0 has a block; held high until acked.
- req0_data  in  DATA_W  ch0 plaintext block; stable while req0_valid is high.
- req0_ack  out  1  one-cycle pulse: ch0 block captured.
- req1_valid  in  1  ch1 has a block.
- req1_data  in  DATA_W  ch1 plaintext block.
- req1_ack  out  1  one-cycle pulse: ch1 block captured.
- core_start  out  1  one-cycle strobe to the AES core ready input.
- core_data_in  out  DATA_W  block presented to the core; held from ISSUE until the next capture.
- core_complete  in  1  core done pulse.
- core_data_out  in  DATA_W  ciphertext; valid in the core_complete cycle.
- res_full  in  1  downstream FIFO full (backpressure).
- res_valid  out  1  one-cycle pulse: result delivered.
- res_data  out  DATA_W  ciphertext block.
- res_tag  out  1  source channel of res_data.
- busy  out  1  high in every state except IDLE.
- blk_count  out  CNT_W  number of blocks delivered; wraps modulo 2^CNT_W.
- timeout_err  out  1  sticky watchdog error (tied 0 without the optional feature).

Behaviour:
- Reset (asynchronous, n_rst low): state IDLE, priority pointer = ch0, all outputs 0 (acks, core_start, res_valid, busy, blk_count, timeout_err, data and tag registers).
- The FSM states are IDLE, ISSUE, BUSY and DELIVER. All outputs are registered.
- IDLE:
  - If any req_valid is high, select a channel. If only one is valid, take it. If both are valid, take the pointer's channel.
  - Capture its data into core_data_in and the channel into the tag, pulse that channel's ack in the next cycle, and go to ISSUE.
  - Latency from req_valid to ack is 1 cycle.
- ISSUE: core_start = 1 for exactly one cycle, then go to BUSY.
- BUSY:
  - Wait for core_complete. On it, capture core_data_out into res_data and go to DELIVER.
  - core_complete in IDLE, ISSUE or DELIVER is ignored and changes no state.
- DELIVER:
  - If res_full = 0, pulse res_valid with res_data and res_tag stable, increment blk_count, set pointer = other channel, and go to IDLE.
  - If res_full = 1, hold in DELIVER with res_data held. No new request is accepted.
- Minimum turnaround is IDLE→ISSUE→BUSY(≥1)→DELIVER→IDLE, i.e. 4 + core latency cycles per block.
- The pointer advances only on delivery. A lone requester is therefore never starved, and alternation is guaranteed when both channels stay valid.
- A requester dropping valid before its ack is a protocol violation; behaviour is unspecified but must not hang the FSM.
- blk_count wraps from 2^CNT_W−1 to 0.
- Reset mid-operation aborts any in-flight block and discards it. No ack or res_valid is produced for it.

Optional Feature:
- Macro name: AES_SCHED_WATCHDOG_EN.
- Defined:
  - A counter runs while BUSY and clears on entry to BUSY.
  - If it reaches TIMEOUT_CYCLES without core_complete: set timeout_err (sticky until reset), drop the block without asserting res_valid, advance the pointer, and return to IDLE.
- Undefined: no counter, timeout_err tied 0, and BUSY waits indefinitely.

Test Plan:
- Single block: req0_valid with data 0x00112233445566778899AABBCCDDEEFF; core model completes after 20 cycles with 0x69C4E0D86A7B0430D8CDB78070B4C55A.
  - Expect req0_ack 1 cycle after valid, then core_start one cycle later.
  - Expect res_valid with that ciphertext, res_tag = 0, blk_count = 1.
- Contention: req0 and req1 valid continuously for 4 blocks → grant order ch0, ch1, ch0, ch1; res_tag sequence 0,1,0,1; blk_count = 4.
- Backpressure: res_full held high for 10 cycles after complete.
  - Expect res_valid to stay 0 and the FSM to hold DELIVER with no new ack.
  - After res_full drops, expect res_valid 1 cycle later.
- Spurious complete: core_complete pulsed in IDLE and in ISSUE → no state change, no res_valid, blk_count unchanged.
- Reset mid-BUSY: n_rst low for 2 cycles during BUSY → all outputs 0. A later core_complete is ignored; the next request then proceeds normally.
- Watchdog (AES_SCHED_WATCHDOG_EN defined, TIMEOUT_CYCLES = 8): core never completes.
  - Expect timeout_err = 1 at cycle 8 of BUSY, no res_valid, and a return to IDLE.
  - Expect a queued req1 to be granted next.
